// File: rtl/led_sweep_pkg.sv
// Shared definitions for the LED sweep sequencer.
// Contents: FSM state type, LED count, displayed positions per sweep and the
// top (MSB) position index.
package led_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } sweep_state_t;

   localparam int         NLEDS       = 8;
   localparam int         SWEEP_STEPS = 14;
   localparam logic [2:0] POS_TOP     = 3'd7;

endpackage

// File: rtl/led_sweep_ctrl_prescaler.sv
// step_prescaler: down-counter with reload that produces the LED step pulse.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_load          force-load i_divider (start of a sequence)
//   i_divider       value loaded on i_load and reloaded when the count hits 0
//   o_step          high while the count is 0
module step_prescaler #(
   parameter int DIV_W = 24
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_divider,
   output logic             o_step
);

   logic [DIV_W-1:0] r_cnt;

   // Count down to 0, then reload; the counter never exceeds the divider, so
   // the all-ones divider cannot wrap.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= {DIV_W{1'b0}};
      end else if (i_load) begin
         r_cnt <= i_divider;
      end else if (r_cnt == {DIV_W{1'b0}}) begin
         r_cnt <= i_divider;
      end else begin
         r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_step = (r_cnt == {DIV_W{1'b0}});

endmodule

// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: sequencer for the bidirectional one-hot LED sweep.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_stb           start request (IDLE only), latches i_count/i_divider
//   i_count         number of full sweeps, 0 = continuous
//   i_divider       clocks per LED step minus 1
//   i_stop          abort request (busy only)
//   o_led           one-hot LED drive while busy, 0 while idle
//   o_busy          sequence running
//   o_done          one-cycle pulse when a sequence ends
module led_sweep_ctrl
   import led_sweep_pkg::*;
#(
   parameter int DIV_W = 24,
   parameter int NLEDS = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_stb,
   input  logic [3:0]       i_count,
   input  logic [DIV_W-1:0] i_divider,
   input  logic             i_stop,
   output logic [NLEDS-1:0] o_led,
   output logic             o_busy,
   output logic             o_done
);

   sweep_state_t     r_state, w_state_nxt;
   logic [2:0]       r_pos, w_pos_nxt;
   logic [3:0]       r_remain, w_remain_nxt;
   logic [DIV_W-1:0] r_period, w_period_nxt;
   logic [DIV_W-1:0] w_div;
   logic             w_load;
   logic             w_step;
   logic             w_done_nxt;
   logic [NLEDS-1:0] r_led;
   logic             r_busy;
   logic             r_done;

   // Loads only happen from IDLE, so the raw input feeds the load and the
   // latched period feeds every reload while busy.
   assign w_div = (r_state == IDLE) ? i_divider : r_period;

   step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_load),
      .i_divider (w_div),
      .o_step    (w_step)
   );

   // Next-state logic: start, step advance, sweep accounting and stop.
   always_comb begin
      w_state_nxt  = r_state;
      w_pos_nxt    = r_pos;
      w_remain_nxt = r_remain;
      w_period_nxt = r_period;
      w_done_nxt   = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_stb) begin
               w_state_nxt  = LEFT;
               w_pos_nxt    = 3'd0;
               w_remain_nxt = i_count;
               w_period_nxt = i_divider;
               w_load       = 1'b1;
            end else begin
               w_pos_nxt = 3'd0;
            end
         end
         LEFT: begin
            if (i_stop) begin
               w_state_nxt = IDLE;
               w_pos_nxt   = 3'd0;
               w_done_nxt  = 1'b1;
            end else if (w_step) begin
               w_pos_nxt = r_pos + 3'd1;
               if (r_pos == (POS_TOP - 3'd1)) begin
                  w_state_nxt = RIGHT;
               end else begin
                  w_state_nxt = LEFT;
               end
            end else begin
               w_state_nxt = LEFT;
            end
         end
         RIGHT: begin
            if (i_stop) begin
               w_state_nxt = IDLE;
               w_pos_nxt   = 3'd0;
               w_done_nxt  = 1'b1;
            end else if (w_step) begin
               if (r_pos > 3'd1) begin
                  w_pos_nxt = r_pos - 3'd1;
               end else if (r_remain == 4'd0) begin
                  // continuous mode: remaining count stays 0 forever
                  w_pos_nxt   = 3'd0;
                  w_state_nxt = LEFT;
               end else if (r_remain > 4'd1) begin
                  w_remain_nxt = r_remain - 4'd1;
                  w_pos_nxt    = 3'd0;
                  w_state_nxt  = LEFT;
               end else begin
                  w_pos_nxt   = 3'd0;
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_state_nxt = RIGHT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_pos_nxt   = 3'd0;
         end
      endcase
   end

   // State, datapath and registered outputs derived from the next state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_pos    <= 3'd0;
         r_remain <= 4'd0;
         r_period <= {DIV_W{1'b0}};
         r_led    <= {NLEDS{1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pos    <= w_pos_nxt;
         r_remain <= w_remain_nxt;
         r_period <= w_period_nxt;
         r_busy   <= (w_state_nxt != IDLE);
         r_done   <= w_done_nxt;
         if (w_state_nxt != IDLE) begin
            r_led <= {{(NLEDS-1){1'b0}}, 1'b1} << w_pos_nxt;
         end else begin
            r_led <= {NLEDS{1'b0}};
         end
      end
   end

   assign o_led  = r_led;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Self-checking bench for led_sweep_ctrl: directed scenarios followed by
// randomized stimulus, all compared against an arithmetic reference model.
module tb_led_sweep_ctrl;
   import led_sweep_pkg::*;

   localparam int TB_DIV_W = 24;

   logic                i_clk = 1'b0;
   logic                i_reset = 1'b1;
   logic                i_stb = 1'b0;
   logic [3:0]          i_count = 4'd0;
   logic [TB_DIV_W-1:0] i_divider = '0;
   logic                i_stop = 1'b0;
   logic [7:0]          o_led;
   logic                o_busy;
   logic                o_done;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: elapsed cycles since start, latched count and divider
   bit m_busy = 1'b0;
   bit m_done = 1'b0;
   int m_k = 0;
   int m_c = 0;
   int m_d = 0;

   led_sweep_ctrl #(.DIV_W(TB_DIV_W), .NLEDS(8)) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_stb     (i_stb),
      .i_count   (i_count),
      .i_divider (i_divider),
      .i_stop    (i_stop),
      .o_led     (o_led),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Position displayed k cycles into a run: index into the 14-step sweep
   // 0,1..7,6..1 repeated.
   function automatic logic [7:0] model_led();
      int idx;
      int ph;
      int pos;
      if (!m_busy) return 8'h00;
      idx = m_k / (m_d + 1);
      ph  = idx % SWEEP_STEPS;
      pos = (ph <= 7) ? ph : (SWEEP_STEPS - ph);
      return 8'(32'd1 << pos);
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      m_done = 1'b0;
      if (i_reset) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (i_stb) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_c    = int'(i_count);
            m_d    = int'(i_divider);
         end
      end else if (i_stop) begin
         m_busy = 1'b0;
         m_done = 1'b1;
      end else begin
         m_k++;
         if (m_c != 0 && (m_k / (m_d + 1)) == SWEEP_STEPS * m_c) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end
   endtask

   task automatic tick(input logic rst, input logic stb, input logic stp,
                       input logic [3:0] cnt, input logic [TB_DIV_W-1:0] div);
      i_reset   = rst;
      i_stb     = stb;
      i_stop    = stp;
      i_count   = cnt;
      i_divider = div;
      @(posedge i_clk);
      model_edge();
      #1;
      check_eq("led", 32'(o_led), 32'(model_led()));
      check_eq("busy", 32'(o_busy), 32'(m_busy));
      check_eq("done", 32'(o_done), 32'(m_done));
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'd0, '0);
   endtask

   initial begin
      // reset state
      tick(1'b1, 1'b0, 1'b0, 4'd0, '0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, '0);
      check_eq("reset_led", 32'(o_led), 32'h0);

      // reset mid-run
      tick(1'b0, 1'b1, 1'b0, 4'd3, 24'd2);
      idle_ticks(19);
      tick(1'b1, 1'b0, 1'b0, 4'd0, '0);
      idle_ticks(10);

      // single sweep, divider 0
      tick(1'b0, 1'b1, 1'b0, 4'd1, 24'd0);
      check_eq("start_led", 32'(o_led), 32'h01);
      idle_ticks(13);
      check_eq("last_pos", 32'(o_led), 32'h02);
      tick(1'b0, 1'b0, 1'b0, 4'd0, '0);
      check_eq("sweep_done", 32'(o_done), 32'h1);
      idle_ticks(2);

      // two sweeps, divider 3: 112 busy cycles
      tick(1'b0, 1'b1, 1'b0, 4'd2, 24'd3);
      idle_ticks(115);

      // continuous mode, then stop
      tick(1'b0, 1'b1, 1'b0, 4'd0, 24'd0);
      idle_ticks(49);
      tick(1'b0, 1'b0, 1'b1, 4'd0, '0);
      check_eq("stop_done", 32'(o_done), 32'h1);
      idle_ticks(2);

      // ignored start while busy, stop in idle, stop coincident with a step
      tick(1'b0, 1'b1, 1'b0, 4'd1, 24'd1);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 4'd3, 24'd0);
      idle_ticks(24);
      tick(1'b0, 1'b0, 1'b1, 4'd0, '0);
      tick(1'b0, 1'b1, 1'b0, 4'd1, 24'd1);
      tick(1'b0, 1'b0, 1'b0, 4'd0, '0);
      tick(1'b0, 1'b0, 1'b1, 4'd0, '0);
      idle_ticks(2);

      // back-to-back restart in the done cycle
      tick(1'b0, 1'b1, 1'b0, 4'd1, 24'd0);
      idle_ticks(14);
      check_eq("b2b_done", 32'(o_done), 32'h1);
      tick(1'b0, 1'b1, 1'b0, 4'd1, 24'd0);
      check_eq("b2b_led", 32'(o_led), 32'h01);
      idle_ticks(15);

      // maximum divider holds position 0, then abort
      tick(1'b0, 1'b1, 1'b0, 4'd1, 24'hFFFFFF);
      idle_ticks(20);
      tick(1'b0, 1'b0, 1'b1, 4'd0, '0);

      // randomized stimulus
      for (int i = 0; i < 4000; i++) begin
         logic          r_rst;
         logic          r_stb;
         logic          r_stp;
         logic [3:0]    r_cnt;
         logic [23:0]   r_div;
         r_rst = ($urandom % 600) == 0;
         r_stb = ($urandom % 8) == 0;
         r_stp = m_busy ? (($urandom % 150) == 0) : (($urandom % 10) == 0);
         r_cnt = 4'($urandom % 4);
         r_div = 24'($urandom % 4);
         tick(r_rst, r_stb, r_stp, r_cnt, r_div);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/led_sweep_ctrl.md
# led_sweep_ctrl

Sequencer for the 8-LED bidirectional sweep display. It accepts a start request carrying a sweep count and a step rate, then drives a one-hot LED pattern (0x01 up to 0x80 and back) at the requested rate. It stops after the requested number of sweeps, or on an explicit stop request, and reports busy and done status to the requesting logic. It sits between board-level control logic (buttons, UART command decoder) and the LED pins.

## Interface
- DIV_W, 24, width of the step-rate divider; the maximum step period is 2^DIV_W clocks.
- NLEDS, 8, number of LEDs; fixed at 8 for this revision.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  reset, synchronous and active-high.
- i_stb  in  1  start request; sampled only in IDLE.
- i_count  in  4  number of full sweeps; 0 means run continuously until stopped.
- i_divider  in  DIV_W  clocks per LED step, minus 1.
- i_stop  in  1  abort request; sampled only while busy.
- o_led  out  8  LED drive; one-hot while busy, 0x00 while idle.
- o_busy  out  1  high while a sweep sequence is running.
- o_done  out  1  one-cycle pulse when a sequence ends, by completion or stop.

## Operation
- The state machine has three states: IDLE, LEFT (moving toward the MSB) and RIGHT (moving toward the LSB).
- Reset:
  - State returns to IDLE, and o_led, o_busy and o_done all go to 0.
  - Reset overrides every other input and takes effect mid-sweep.
- IDLE + i_stb:
  - Latch i_count into the remaining counter and i_divider into the period register.
  - Set position to 0 and load the prescaler with the divider value.
  - Enter LEFT; o_led becomes 0x01 and o_busy becomes 1.
- A step pulse is generated when the prescaler reaches 0. On a step pulse the prescaler reloads the latched divider. Otherwise the prescaler decrements by 1 each cycle.
- LEFT on a step: position increments by 1. When position reaches 7, the state becomes RIGHT.
- RIGHT on a step, from position p > 1: position becomes p-1.
- RIGHT on a step, from position 1, one of three cases applies:
  - Continuous mode (latched count 0): position becomes 0 and the state becomes LEFT.
  - Remaining count > 1: decrement the remaining count; position becomes 0 and the state becomes LEFT.
  - Remaining count == 1 (last sweep): enter IDLE, set o_led to 0x00, o_busy to 0, and pulse o_done.
- Sweep and output shape:
  - One sweep is 14 displayed positions: 0,1..7,6..1.
  - o_led always equals 1 << position while busy.
- i_stop while busy:
  - On the next edge, enter IDLE with o_led 0x00, o_busy 0, o_done 1.
  - Stop has priority over a coincident step.
- Ignored inputs:
  - i_stb while busy is ignored, and i_count/i_divider are not re-latched.
  - i_stop in IDLE is ignored.
  - If i_stb and i_stop are asserted together in IDLE, the start proceeds.
- Invariants (formal targets):
  - o_busy implies o_led is one-hot; !o_busy implies o_led == 0.
  - o_done implies !o_busy.
  - Position never exceeds 7.

## Timing
- Start latency: i_stb sampled at edge N gives o_led = 0x01 and o_busy = 1 from edge N onward.
- Each position is held for exactly i_divider+1 cycles.
- Completion:
  - o_busy stays high for 14 × (D+1) × count cycles.
  - o_done is high for exactly 1 cycle, the same cycle in which o_busy first reads 0.
- Stop latency is 1 edge. No partial step is emitted after a stop.
- A new i_stb is accepted in the same cycle o_done is high, because the state is already IDLE.
- Divider 0 steps every cycle. The maximum divider, 2^DIV_W−1, must not overflow the prescaler.

## Structure
- Shared package led_sweep_pkg contains:
  - The state enum {IDLE, LEFT, RIGHT}.
  - NLEDS = 8.
  - SWEEP_STEPS = 14.
  - The top position constant, 7.
- Sub-module step_prescaler contains:
  - Inputs: load, divider; output: step pulse.
  - A down-counter with reload, DIV_W wide.
  - It is instantiated once. The state machine, position register and remaining counter live in led_sweep_ctrl.

## Test plan
- Reset mid-run: start (count 3, div 2), then assert i_reset at cycle 20 → next edge o_led = 0x00, o_busy = 0, o_done = 0; no done pulse follows.
- Single sweep, div 0: start count 1 → o_led sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02 on consecutive cycles, then 00 with o_done = 1; o_busy high for exactly 14 cycles.
- Rate and count: count 2, div 3 → each value held 4 cycles, o_busy high for 112 cycles, exactly one o_done pulse.
- Continuous mode: count 0, div 0, run 50 cycles → pattern period 14 with no o_done; i_stop at cycle 50 → 00 and o_done on the next edge.
- Ignored and coincident inputs, all with count 1, div 1:
  - i_stb while busy, with different i_count/i_divider → no change to timing.
  - i_stop in IDLE → no effect.
  - i_stop on the same cycle as a step → stop wins.
- Back-to-back: re-assert i_stb in the o_done cycle → o_led = 0x01 and o_busy = 1 on the next edge, with no idle gap beyond that one cycle.
